boundary_generator: RTL and testbench



---
 rtl/boundary_generator.sv | 183 ++++++++++++++++++
 tb/tb_boundary_generator.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/boundary_generator.sv
// LFSR-driven clamped random walk that feeds one river-bank row per scroll tick into the boundary array.
// Optional macro BOUNDARY_STRAIGHT_START_EN: hold the first START_ROWS rows at INIT_BOUND before the walk starts.
module boundary_generator #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 8,
    parameter int INIT_BOUND = 160,
    parameter int MIN_BOUND  = 64,
    parameter int MAX_BOUND  = 288,
    parameter int MAX_STEP   = 8,
    parameter int SEG_LEN    = 16,
    parameter int START_ROWS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scrollTick,
    output logic                  enableSig,
    output logic                  operationSig,
    output logic [DATA_WIDTH-1:0] boundaryInput,
    output logic                  direction,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  busy,
    output logic                  overrun
);

    localparam int EXT_W  = DATA_WIDTH + 1;
    localparam int STEP_W = $clog2(MAX_STEP + 1);
    localparam int SEG_W  = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [DATA_WIDTH-1:0] INIT_D = DATA_WIDTH'(INIT_BOUND);
    localparam logic [DATA_WIDTH-1:0] MIN_D  = DATA_WIDTH'(MIN_BOUND);
    localparam logic [DATA_WIDTH-1:0] MAX_D  = DATA_WIDTH'(MAX_BOUND);
    localparam logic [EXT_W-1:0]      MIN_EXT = EXT_W'(MIN_BOUND);
    localparam logic [EXT_W-1:0]      MAX_EXT = EXT_W'(MAX_BOUND);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN   = 2'd1,
        ST_CALC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    function automatic logic [STEP_W-1:0] draw_step(input logic [2:0] bits);
        int s;
        s = (int'(bits) % MAX_STEP) + 1;
        return STEP_W'(s);
    endfunction

    state_t                 state_r;
    logic [15:0]            lfsr_r;
    logic [15:0]            lfsr_next_s;
    logic [DATA_WIDTH-1:0]  cur_r;
    logic [DATA_WIDTH-1:0]  next_r;
    logic                   cur_dir_r;
    logic [STEP_W-1:0]      cur_step_r;
    logic [SEG_W-1:0]       seg_cnt_r;
    logic [SEG_W-1:0]       seg_next_s;
    logic [EXT_W-1:0]       raw_s;
    logic                   neg_s;
    logic [DATA_WIDTH-1:0]  calc_next_s;
    logic                   calc_dir_s;
    logic                   straight_s;

    assign lfsr_next_s = lfsr_step(lfsr_r);
    assign seg_next_s  = (seg_cnt_r == SEG_W'(SEG_LEN - 1)) ? {SEG_W{1'b0}} : seg_cnt_r + SEG_W'(1);
    assign address     = {ADDR_WIDTH{1'b0}};

    // Candidate next bank position, widened one bit so overshoot and underflow are visible before clamping.
    always_comb begin
        raw_s       = {1'b0, cur_r} + EXT_W'(cur_step_r);
        neg_s       = 1'b0;
        calc_next_s = cur_r;
        calc_dir_s  = cur_dir_r;
        if (cur_dir_r) begin
            raw_s = {1'b0, cur_r} - EXT_W'(cur_step_r);
            neg_s = ({1'b0, cur_r} < EXT_W'(cur_step_r));
        end else begin
            raw_s = {1'b0, cur_r} + EXT_W'(cur_step_r);
            neg_s = 1'b0;
        end
        if (!neg_s && (raw_s > MAX_EXT)) begin
            calc_next_s = MAX_D;
            calc_dir_s  = 1'b1;
        end else if (neg_s || (raw_s < MIN_EXT)) begin
            calc_next_s = MIN_D;
            calc_dir_s  = 1'b0;
        end else begin
            calc_next_s = raw_s[DATA_WIDTH-1:0];
            calc_dir_s  = cur_dir_r;
        end
    end

`ifdef BOUNDARY_STRAIGHT_START_EN
    localparam int START_W = (START_ROWS > 0) ? $clog2(START_ROWS + 1) : 1;
    logic [START_W-1:0] start_cnt_r;

    assign straight_s = (start_cnt_r < START_W'(START_ROWS));

    // Counts written rows until the straight opening section is complete.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_cnt_r <= {START_W{1'b0}};
        end else if ((state_r == ST_WRITE) && straight_s) begin
            start_cnt_r <= start_cnt_r + START_W'(1);
        end else begin
            start_cnt_r <= start_cnt_r;
        end
    end
`else
    // Without the opening section the walk starts at the first row.
    assign straight_s = (START_ROWS < 0) ? 1'b1 : 1'b0;
`endif

    // Row generation FSM with registered array strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            lfsr_r        <= LFSR_SEED;
            cur_r         <= INIT_D;
            next_r        <= INIT_D;
            cur_dir_r     <= 1'b0;
            cur_step_r    <= STEP_W'(1);
            seg_cnt_r     <= {SEG_W{1'b0}};
            enableSig     <= 1'b0;
            operationSig  <= 1'b0;
            boundaryInput <= INIT_D;
            direction     <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            enableSig    <= 1'b0;
            operationSig <= 1'b0;
            if (scrollTick && (state_r != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (scrollTick) begin
                        state_r <= ST_GEN;
                        busy    <= 1'b1;
                    end
                end
                ST_GEN: begin
                    lfsr_r <= lfsr_next_s;
                    if (!straight_s && (seg_cnt_r == {SEG_W{1'b0}})) begin
                        cur_dir_r  <= lfsr_next_s[0];
                        cur_step_r <= draw_step(lfsr_next_s[3:1]);
                    end
                    state_r <= ST_CALC;
                end
                ST_CALC: begin
                    if (straight_s) begin
                        next_r    <= INIT_D;
                        cur_dir_r <= 1'b0;
                    end else begin
                        next_r    <= calc_next_s;
                        cur_dir_r <= calc_dir_s;
                        seg_cnt_r <= seg_next_s;
                    end
                    state_r <= ST_WRITE;
                end
                ST_WRITE: begin
                    enableSig     <= 1'b1;
                    operationSig  <= 1'b1;
                    boundaryInput <= next_r;
                    direction     <= cur_dir_r;
                    cur_r         <= next_r;
                    busy          <= 1'b0;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boundary_generator.sv
// Directed bench for boundary_generator: a default instance plus one with a low ceiling to exercise clamping.
module tb_boundary_generator;

    localparam int DW    = 10;
    localparam int AW    = 8;
    localparam int C_MAX = 170;

    logic clk = 1'b0;
    logic reset;
    logic scrollTick;
    logic en_a, op_a, dir_a, busy_a, ovr_a;
    logic en_c, op_c, dir_c, busy_c, ovr_c;
    logic [DW-1:0] bnd_a, bnd_c;
    logic [AW-1:0] addr_a, addr_c;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int a;
        int da;
        int c;
        int dc;
    } vec_t;
    vec_t vec[16];

    always #5 clk = ~clk;

    boundary_generator dut (
        .clk(clk), .reset(reset), .scrollTick(scrollTick),
        .enableSig(en_a), .operationSig(op_a), .boundaryInput(bnd_a),
        .direction(dir_a), .address(addr_a), .busy(busy_a), .overrun(ovr_a)
    );

    boundary_generator #(.MAX_BOUND(C_MAX)) dut_c (
        .clk(clk), .reset(reset), .scrollTick(scrollTick),
        .enableSig(en_c), .operationSig(op_c), .boundaryInput(bnd_c),
        .direction(dir_c), .address(addr_c), .busy(busy_c), .overrun(ovr_c)
    );

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_ok(input string name, input bit ok, input int got);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d outside the allowed set", name, got);
        end
    endtask

    function automatic bit dir_ok(input int prev, input int val, input int dir, input int lo, input int hi);
        if (val > prev) return (dir == 0) || (val == hi);
        else if (val < prev) return (dir == 1) || (val == lo);
        else return ((val == hi) && (dir == 1)) || ((val == lo) && (dir == 0));
    endfunction

    // One accepted tick at 4-cycle spacing; checks latency, busy window and strobe count.
    task automatic run_tick(output int va, output int da, output int vc, output int dc);
        int na, nc;
        na = 0; nc = 0; va = -1; da = -1; vc = -1; dc = -1;
        scrollTick = 1'b1;
        @(negedge clk);
        scrollTick = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (en_a) begin
                na++; va = bnd_a; da = dir_a;
                check("strobe_cycle", k, 3);
                check("op_with_en", op_a, 1);
                check("address", addr_a, 0);
            end
            if (en_c) begin
                nc++; vc = bnd_c; dc = dir_c;
            end
            check("busy_window", busy_a, (k < 3) ? 1 : 0);
            if (k < 3) @(negedge clk);
        end
        check("strobes_a", na, 1);
        check("strobes_c", nc, 1);
    endtask

    task automatic count_strobes(input int cycles, output int na, output int nc);
        na = 0; nc = 0;
        for (int k = 0; k < cycles; k++) begin
            if (en_a) na++;
            if (en_c) nc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int va, da, vc, dc, pa, pc, first_val, total, na, nc;
        reset = 1'b1;
        scrollTick = 1'b0;

`ifdef BOUNDARY_STRAIGHT_START_EN
        for (int i = 0; i < 16; i++) vec[i] = '{160, 0, 160, 0};
`else
        vec[0]  = '{161, 0, 161, 0};
        vec[1]  = '{162, 0, 162, 0};
        vec[2]  = '{163, 0, 163, 0};
        vec[3]  = '{164, 0, 164, 0};
        vec[4]  = '{165, 0, 165, 0};
        vec[5]  = '{166, 0, 166, 0};
        vec[6]  = '{167, 0, 167, 0};
        vec[7]  = '{168, 0, 168, 0};
        vec[8]  = '{169, 0, 169, 0};
        vec[9]  = '{170, 0, 170, 0};
        vec[10] = '{171, 0, 170, 1};
        vec[11] = '{172, 0, 169, 1};
        vec[12] = '{173, 0, 168, 1};
        vec[13] = '{174, 0, 167, 1};
        vec[14] = '{175, 0, 166, 1};
        vec[15] = '{176, 0, 165, 1};
`endif

        repeat (3) @(negedge clk);
        check("rst_en", en_a, 0);
        check("rst_op", op_a, 0);
        check("rst_bound", bnd_a, 160);
        check("rst_dir", dir_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_overrun", ovr_a, 0);
        reset = 1'b0;
        repeat (7) @(negedge clk);

        // Table rows: first segment of the walk, default and low-ceiling instances.
        total = 0;
        for (int i = 0; i < 16; i++) begin
            run_tick(va, da, vc, dc);
            total++;
            check($sformatf("vec%0d_a", i), va, vec[i].a);
            check($sformatf("vec%0d_da", i), da, vec[i].da);
            check($sformatf("vec%0d_c", i), vc, vec[i].c);
            check($sformatf("vec%0d_dc", i), dc, vec[i].dc);
        end
        first_val = vec[0].a;
        pa = vec[15].a;
        pc = vec[15].c;

        // Long run at minimum spacing: range, step size and direction consistency.
        for (int i = 16; i < 1000; i++) begin
            bit walk;
            run_tick(va, da, vc, dc);
            total++;
            walk = 1'b1;
`ifdef BOUNDARY_STRAIGHT_START_EN
            walk = (i >= 32);
            if (i < 32) begin
                check("straight_val", va, 160);
                check("straight_dir", da, 0);
            end
            if (i == 32) check_ok("first_walk_delta", (va != 160) && (va >= 152) && (va <= 168), va);
`endif
            check_ok("range_a", (va >= 64) && (va <= 288), va);
            check_ok("range_c", (vc >= 64) && (vc <= C_MAX), vc);
            check_ok("delta_a", (va - pa <= 8) && (pa - va <= 8), va - pa);
            check_ok("delta_c", (vc - pc <= 8) && (pc - vc <= 8), vc - pc);
            if (walk) begin
                check_ok("dir_a", dir_ok(pa, va, da, 64, 288), da);
                check_ok("dir_c", dir_ok(pc, vc, dc, 64, C_MAX), dc);
            end
            pa = va;
            pc = vc;
        end
        check("total_strobes", total, 1000);
        check("overrun_clean", ovr_a, 0);

        // Ticks 2 cycles apart: the second lands in CALC and is dropped.
        scrollTick = 1'b1;
        @(negedge clk);
        scrollTick = 1'b0;
        @(negedge clk);
        scrollTick = 1'b1;
        @(negedge clk);
        scrollTick = 1'b0;
        check("overrun_set", ovr_a, 1);
        count_strobes(8, na, nc);
        check("spacing2_strobes_a", na, 1);
        check("spacing2_strobes_c", nc, 1);

        // Tick coinciding with the WRITE to IDLE return is dropped too.
        scrollTick = 1'b1;
        @(negedge clk);
        scrollTick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        scrollTick = 1'b1;
        @(negedge clk);
        scrollTick = 1'b0;
        count_strobes(8, na, nc);
        check("spacing3_strobes_a", na, 1);
        repeat (20) @(negedge clk);
        check("overrun_sticky", ovr_a, 1);
        run_tick(va, da, vc, dc);
        check("overrun_after_tick", ovr_a, 1);

        // Reset while the strobe is up must kill it without waiting for a clock.
        scrollTick = 1'b1;
        @(negedge clk);
        scrollTick = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_strobe", en_a, 1);
        reset = 1'b1;
        #1;
        check("async_en_drop", en_a, 0);
        check("async_op_drop", op_a, 0);
        check("reset_bound", bnd_a, 160);
        check("reset_overrun", ovr_a, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run_tick(va, da, vc, dc);
        check("fresh_after_write_reset", va, first_val);

        // Reset while in CALC aborts the row entirely.
        scrollTick = 1'b1;
        @(negedge clk);
        scrollTick = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("calc_reset_en", en_a, 0);
        check("calc_reset_busy", busy_a, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        count_strobes(6, na, nc);
        check("calc_reset_no_write", na, 0);
        check("calc_reset_bound", bnd_a, 160);
        run_tick(va, da, vc, dc);
        check("fresh_after_calc_reset", va, first_val);
        check("fresh_after_calc_reset_dir", da, vec[0].da);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
